// File: rtl/dmem_ctrl.sv
// Byte-addressed, big-endian data memory for the MEM stage with request/response handshake.
// Misaligned accesses span two rows and take an extra SPLIT cycle; a zero-clear sweep runs after reset.
module dmem_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);
    localparam int BYTES     = DATA_W / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int ROW_W     = $clog2(DEPTH);
    localparam int LAST_BYTE = DEPTH * BYTES - 1;

    typedef enum logic [1:0] {CLEAR, IDLE, SPLIT} state_t;

    state_t state, next_state;
    logic [ROW_W-1:0] clr_idx;
    logic [7:0] mem [DEPTH][BYTES];

    logic [ROW_W-1:0]  lat_row;
    logic [OFF_W-1:0]  lat_off;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_rdata;
    logic [BYTES-1:0]  lat_be;

    logic              accept;
    logic              req_err;
    logic              req_misaligned;
    logic [ADDR_W:0]   last_addr;
    logic              second;
    logic              mem_we;
    logic              cur_we;
    logic [DATA_W-1:0] cur_wdata;
    logic [BYTES-1:0]  cur_be;
    logic [OFF_W-1:0]  cur_off;
    logic [ROW_W-1:0]  cur_row;
    logic [ROW_W-1:0]  phase_row;
    logic [OFF_W:0]    byte_sum;
    logic [BYTES-1:0]  byte_hit;
    logic [OFF_W-1:0]  byte_pos [BYTES];
    logic [DATA_W-1:0] rd_word;

    assign req_ready      = (state == IDLE) && !rst;
    assign accept         = req_valid && req_ready;
    // One extra bit so addresses near the top of the space cannot wrap into range
    assign last_addr      = {1'b0, req_addr} + (ADDR_W+1)'(BYTES - 1);
    assign req_err        = last_addr > (ADDR_W+1)'(LAST_BYTE);
    assign req_misaligned = req_addr[OFF_W-1:0] != '0;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_idx == ROW_W'(DEPTH - 1)) next_state = IDLE;
            IDLE:    if (accept && !req_err && req_misaligned) next_state = SPLIT;
            SPLIT:   next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    // Byte k of the word sits at offset+k; a carry out of the offset field means it lands in row r+1
    always_comb begin
        second    = (state == SPLIT);
        cur_we    = second ? lat_we    : req_we;
        cur_wdata = second ? lat_wdata : req_wdata;
        cur_be    = second ? lat_be    : req_be;
        cur_off   = second ? lat_off   : req_addr[OFF_W-1:0];
        cur_row   = second ? lat_row   : req_addr[OFF_W +: ROW_W];
        phase_row = cur_row + ROW_W'(second);
        rd_word   = second ? lat_rdata : '0;
        byte_hit  = '0;
        byte_sum  = '0;
        for (int k = 0; k < BYTES; k++) begin
            byte_sum    = {1'b0, cur_off} + (OFF_W+1)'(k);
            byte_pos[k] = byte_sum[OFF_W-1:0];
            byte_hit[k] = (byte_sum[OFF_W] == second);
            if (byte_hit[k]) rd_word[8*(BYTES-1-k) +: 8] = mem[phase_row][byte_pos[k]];
        end
        mem_we = !rst && cur_we && ((accept && !req_err) || second);
    end

    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            for (int b = 0; b < BYTES; b++) mem[clr_idx][b] <= '0;
        end else if (mem_we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (byte_hit[k] && cur_be[BYTES-1-k])
                    mem[phase_row][byte_pos[k]] <= cur_wdata[8*(BYTES-1-k) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (state == CLEAR) clr_idx <= clr_idx + ROW_W'(1);
            if (accept) begin
                if (req_err) begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end else if (!req_misaligned) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= req_we ? '0 : rd_word;
                end else begin
                    lat_row   <= req_addr[OFF_W +: ROW_W];
                    lat_off   <= req_addr[OFF_W-1:0];
                    lat_we    <= req_we;
                    lat_wdata <= req_wdata;
                    lat_be    <= req_be;
                    lat_rdata <= rd_word;
                end
            end else if (second) begin
                resp_valid <= 1'b1;
                resp_rdata <= lat_we ? '0 : rd_word;
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected responses (data, error, due cycle);
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_dmem_ctrl;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 16;
    localparam int BYTES  = DATA_W / 8;

    logic              clk, rst, req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BYTES-1:0]  req_be;
    logic              resp_valid, resp_err;
    logic [DATA_W-1:0] resp_rdata;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                due;
        string             name;
    } exp_t;

    exp_t expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int cycleCount = 0;

    dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_resp: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
            end else begin
                e = expQ.pop_front();
                compared++;
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    mismatched++;
                    $display("[TB] FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                             e.name, resp_rdata, resp_err, e.rdata, e.err);
                end
                compared++;
                if (cycleCount != e.due) begin
                    mismatched++;
                    $display("[TB] FAIL %s_latency: got cycle %0d, required cycle %0d", e.name, cycleCount, e.due);
                end
            end
        end else if (cycleCount > 0 && !rst) begin
            compared++;
            if (resp_rdata !== '0 || resp_err !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_outputs: got rdata=%h err=%b, required 0 0", resp_rdata, resp_err);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // Called at a negedge; issues one request and records the response it should produce lat cycles later
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                 input logic [BYTES-1:0] be, input logic [DATA_W-1:0] expRdata,
                                 input logic expErr, input int lat, input string name);
        exp_t e;
        int waitCount = 0;
        while (req_ready !== 1'b1 && waitCount < 100) begin
            @(negedge clk);
            waitCount++;
        end
        if (req_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_ready_timeout: got req_ready=%b, required 1", name, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        e.rdata = expRdata;
        e.err   = expErr;
        e.due   = cycleCount + lat;
        e.name  = name;
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitClear(input string name);
        int lowCount = 0;
        while (req_ready !== 1'b1 && lowCount < 100) begin
            lowCount++;
            @(negedge clk);
        end
        checkOutput(name, lowCount, DEPTH);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", req_ready, 0);
        checkOutput("reset_resp_valid", resp_valid, 0);
        checkOutput("reset_rdata", resp_rdata, 0);
        checkOutput("reset_err", resp_err, 0);
        rst = 1'b0;
        waitClear("clear_length");

        applyStimulus(0, 16'd0,  16'h0000, 2'b11, 16'h0000, 0, 1, "rd_clear_0");
        applyStimulus(0, 16'd62, 16'h0000, 2'b11, 16'h0000, 0, 1, "rd_clear_62");

        applyStimulus(1, 16'd8, 16'h12AB, 2'b11, 16'h0000, 0, 1, "wr_8");
        applyStimulus(0, 16'd8, 16'h0000, 2'b00, 16'h12AB, 0, 1, "rd_8");
        applyStimulus(0, 16'd9, 16'h0000, 2'b11, 16'hAB00, 0, 2, "rd_9_split");
        checkOutput("split_ready_low", req_ready, 0);
        @(negedge clk);
        checkOutput("split_ready_back", req_ready, 1);

        applyStimulus(1, 16'd10, 16'hFFFF, 2'b01, 16'h0000, 0, 1, "wr_10_be01");
        applyStimulus(0, 16'd10, 16'h0000, 2'b11, 16'h00FF, 0, 1, "rd_10_a");
        applyStimulus(1, 16'd10, 16'h3300, 2'b10, 16'h0000, 0, 1, "wr_10_be10");
        applyStimulus(0, 16'd10, 16'h0000, 2'b11, 16'h33FF, 0, 1, "rd_10_b");

        applyStimulus(1, 16'd13, 16'hCAFE, 2'b11, 16'h0000, 0, 2, "wr_13_split");
        applyStimulus(0, 16'd12, 16'h0000, 2'b11, 16'h00CA, 0, 1, "rd_12");
        applyStimulus(0, 16'd14, 16'h0000, 2'b11, 16'hFE00, 0, 1, "rd_14");
        applyStimulus(0, 16'd13, 16'h0000, 2'b11, 16'hCAFE, 0, 2, "rd_13_split");

        // Misaligned partial writes: each lane's enable follows the byte into its row
        applyStimulus(1, 16'd21, 16'hA1B2, 2'b10, 16'h0000, 0, 2, "wr_21_be10");
        applyStimulus(0, 16'd20, 16'h0000, 2'b11, 16'h00A1, 0, 1, "rd_20");
        applyStimulus(0, 16'd22, 16'h0000, 2'b11, 16'h0000, 0, 1, "rd_22");
        applyStimulus(1, 16'd23, 16'hC3D4, 2'b01, 16'h0000, 0, 2, "wr_23_be01");
        applyStimulus(0, 16'd23, 16'h0000, 2'b11, 16'h00D4, 0, 2, "rd_23_split");

        applyStimulus(1, 16'd62,    16'h7788, 2'b11, 16'h0000, 0, 1, "wr_62");
        applyStimulus(0, 16'd63,    16'h0000, 2'b11, 16'h0000, 1, 1, "rd_63_err");
        applyStimulus(1, 16'd63,    16'h5555, 2'b11, 16'h0000, 1, 1, "wr_63_err");
        applyStimulus(0, 16'd62,    16'h0000, 2'b11, 16'h7788, 0, 1, "rd_62_kept");
        applyStimulus(0, 16'hFFFF,  16'h0000, 2'b11, 16'h0000, 1, 1, "rd_ffff_err");
        applyStimulus(0, 16'hFFFE,  16'h0000, 2'b11, 16'h0000, 1, 1, "rd_fffe_err");

        // Reset during SPLIT: the pending response must never appear
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'hBEEF; req_be = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_in_split", req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_resp_valid_0", resp_valid, 0);
        @(negedge clk);
        checkOutput("abort_resp_valid_1", resp_valid, 0);
        rst = 1'b0;
        waitClear("reclear_length");
        applyStimulus(0, 16'd4,  16'h0000, 2'b11, 16'h0000, 0, 1, "rd_4_after_abort");
        applyStimulus(0, 16'd6,  16'h0000, 2'b11, 16'h0000, 0, 1, "rd_6_after_abort");
        applyStimulus(0, 16'd62, 16'h0000, 2'b11, 16'h0000, 0, 1, "rd_62_recleared");

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        checkOutput("responses_outstanding", expQ.size(), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, word-organised, byte-addressed data memory with a request/response handshake for the pipeline's MEM stage. Supports any byte address, including misaligned accesses that span two storage rows, which take an extra cycle. Also supports per-byte write enables, out-of-range error reporting, and a hardware zero-clear sweep after reset. Byte order is big-endian: the lowest address holds the most-significant byte of a word.

## Interface
- DATA_W, 16, word width in bits; power of two, ≥16; BYTES = DATA_W/8
- DEPTH, 32, number of storage rows (words); power of two
- ADDR_W, 16, byte-address width; must satisfy DEPTH*BYTES ≤ 2^ADDR_W

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address of the word's MSB
- req_wdata  in  DATA_W  write data
- req_be  in  BYTES  byte enables; lane i = bits [8i+7:8i]; lane BYTES-1 maps to req_addr, lane 0 to req_addr+BYTES-1
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  access out of range

## Operation
- Storage: DEPTH rows × DATA_W bits. Row = addr >> log2(BYTES); offset = addr mod BYTES.
- Aligned access (offset 0) touches one row. Misaligned access touches row r (bytes offset..BYTES-1) and row r+1 (bytes 0..offset-1).
- States: CLEAR, IDLE, SPLIT.
- CLEAR:
  - Entered on rst. clr_idx is 0 while rst is high.
  - Each cycle with rst low, write zero to row clr_idx and increment clr_idx.
  - After row DEPTH-1 is written, go to IDLE. req_ready = 0 throughout.
- IDLE:
  - req_ready = 1. A handshake occurs on req_valid & req_ready.
  - Range check: error if req_addr + BYTES - 1 > DEPTH*BYTES - 1, computed without ADDR_W overflow. On error, nothing is written (all-or-nothing); respond with resp_err = 1 and resp_rdata = 0.
  - Aligned request, or any error: complete in the accept cycle; stay in IDLE.
  - Misaligned request:
    - Accept cycle: perform the row-r portion and latch addr, we, wdata, be, and the partial read bytes.
    - Go to SPLIT.
- SPLIT:
  - req_ready = 0.
  - Perform the row-r+1 portion. Return to IDLE.
- Writes: only lanes with req_be set are modified. For a misaligned write, each lane's be bit applies to whichever row that lane lands in.
- Reads: assemble the word big-endian from the touched bytes, independent of req_be.
- Writes also generate resp_valid, with rdata = 0.
- No address wrap-around; the error path covers every overflow case.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, state CLEAR, clr_idx 0.
- CLEAR duration: DEPTH cycles after rst deasserts. req_ready rises on the cycle after row DEPTH-1 is cleared.
- Aligned or error request: resp_valid on the cycle after accept (latency 1). Back-to-back requests give one response per cycle.
- Misaligned request: resp_valid 2 cycles after accept. req_ready is low for exactly 1 cycle (SPLIT).
- resp_valid lasts exactly 1 cycle. rdata and err are valid only while resp_valid = 1 and are driven to 0 otherwise.
- rst asserted in any state:
  - Aborts any SPLIT in progress; the pending response is never issued.
  - resp_valid = 0 from the next edge; the CLEAR sweep restarts.
  - A request presented in the same cycle as rst is ignored.
- Write followed by read of the same bytes in the next accepted request returns the new data (no stale read).

## Test plan
- Reset/clear (DATA_W 16, DEPTH 32) -> req_ready is low for 32 cycles after rst falls, then high. Read addr 0 and addr 62 -> rdata 0x0000, err 0.
- Aligned write 0x12AB @8 with be=11, then read @8 -> 0x12AB with latency 1. Then read @9 -> 0xAB00 with latency 2, and req_ready low for 1 cycle.
- Byte enables: write 0xFFFF @10 with be=01, then read @10 -> 0x00FF. Then write 0x3300 @10 with be=10, then read -> 0x33FF.
- Misaligned write 0xCAFE @13 with be=11 -> read @12 = 0x00CA, read @14 = 0xFE00, read @13 = 0xCAFE.
- Out of range:
  - Read @63 -> err 1, rdata 0.
  - Write 0x5555 @63 -> err 1; a follow-up read @62 is unchanged.
  - Read @0xFFFF -> err 1, with no overflow aliasing.
- Reset mid-SPLIT: misaligned write @5, then rst asserted in SPLIT -> no resp_valid, CLEAR re-runs, and read @4 / @6 return 0x0000.
